// File: rtl/enc_pkg.sv
// Shared definitions for the registered 8-to-3 priority encoder.
//   N_REQ : number of request lines
//   IDX_W : width of the encoded index
//   idx_t : encoded index type
package enc_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

endpackage : enc_pkg

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder on an active-high request vector.
// Ports:
//   req_i   : request vector, bit i = request i asserted
//   idx_o   : index of the winning request (0 when no request)
//   any_o   : at least one request asserted
//   multi_o : two or more requests asserted
// HIGH_PRIO = 1 selects the highest asserted index, 0 selects the lowest.
module prio_enc8
  import enc_pkg::*;
#(
  parameter int unsigned HIGH_PRIO = 1
) (
  input  logic [N_REQ-1:0] req_i,
  output idx_t             idx_o,
  output logic             any_o,
  output logic             multi_o
);

  logic seen;

  always_comb begin
    idx_o   = '0;
    seen    = 1'b0;
    multi_o = 1'b0;
    if (HIGH_PRIO != 0) begin
      // Ascending scan: the last asserted index overwrites earlier ones.
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_i[i]) begin
          idx_o = idx_t'(i);
        end
        multi_o = multi_o | (seen & req_i[i]);
        seen    = seen | req_i[i];
      end
    end else begin
      // Descending scan: the lowest asserted index is written last.
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          idx_o = idx_t'(i);
        end
        multi_o = multi_o | (seen & req_i[i]);
        seen    = seen | req_i[i];
      end
    end
    any_o = seen;
  end

endmodule : prio_enc8

// File: rtl/encoder8to3_reg.sv
// Registered 8-to-3 priority encoder with active-low request inputs.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   X0..X7     : request lines, active-low, Xi is index i
//   P2,P1,P0   : registered true-binary index of the winning request
//   valid      : registered, at least one request was asserted
//   multi      : registered, two or more requests were asserted
// Outputs follow the inputs with one cycle of latency; no combinational
// path from inputs to outputs.
module encoder8to3_reg
  import enc_pkg::*;
#(
  parameter int unsigned HIGH_PRIO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic X0,
  input  logic X1,
  input  logic X2,
  input  logic X3,
  input  logic X4,
  input  logic X5,
  input  logic X6,
  input  logic X7,
  output logic P2,
  output logic P1,
  output logic P0,
  output logic valid,
  output logic multi
);

  logic [N_REQ-1:0] w_req;
  idx_t             w_idx;
  logic             w_any;
  logic             w_multi;

  idx_t             r_idx;
  logic             r_valid;
  logic             r_multi;

  assign w_req = ~{X7, X6, X5, X4, X3, X2, X1, X0};

  prio_enc8 #(
    .HIGH_PRIO (HIGH_PRIO)
  ) u_prio_enc8 (
    .req_i   (w_req),
    .idx_o   (w_idx),
    .any_o   (w_any),
    .multi_o (w_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_idx   <= w_idx;
      r_valid <= w_any;
      r_multi <= w_multi;
    end
  end

  assign P2    = r_idx[2];
  assign P1    = r_idx[1];
  assign P0    = r_idx[0];
  assign valid = r_valid;
  assign multi = r_multi;

endmodule : encoder8to3_reg

// File: tb/tb_encoder8to3_reg.sv
// Scoreboard bench: two DUT instances (HIGH_PRIO=1 and 0) share stimulus.
// The driver pushes hand-computed expectations {P2,P1,P0,valid,multi} per
// cycle; the monitor pops and compares one entry after each rising edge.
module tb_encoder8to3_reg;

  typedef struct packed {
    logic [4:0] hi;
    logic [4:0] lo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x   = 8'hff;

  logic hp2, hp1, hp0, hvalid, hmulti;
  logic lp2, lp1, lp0, lvalid, lmulti;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  encoder8to3_reg #(
    .HIGH_PRIO (1)
  ) u_dut_hi (
    .clk   (clk),
    .rst   (rst),
    .X0    (x[0]),
    .X1    (x[1]),
    .X2    (x[2]),
    .X3    (x[3]),
    .X4    (x[4]),
    .X5    (x[5]),
    .X6    (x[6]),
    .X7    (x[7]),
    .P2    (hp2),
    .P1    (hp1),
    .P0    (hp0),
    .valid (hvalid),
    .multi (hmulti)
  );

  encoder8to3_reg #(
    .HIGH_PRIO (0)
  ) u_dut_lo (
    .clk   (clk),
    .rst   (rst),
    .X0    (x[0]),
    .X1    (x[1]),
    .X2    (x[2]),
    .X3    (x[3]),
    .X4    (x[4]),
    .X5    (x[5]),
    .X6    (x[6]),
    .X7    (x[7]),
    .P2    (lp2),
    .P1    (lp1),
    .P0    (lp0),
    .valid (lvalid),
    .multi (lmulti)
  );

  // Drive one cycle of stimulus on the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic [7:0] xv,
                       input logic [4:0] eh, input logic [4:0] el);
    exp_t e;
    @(negedge clk);
    rst  = r;
    x    = xv;
    e.hi = eh;
    e.lo = el;
    q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin : monitor
    exp_t       e;
    logic [4:0] act_hi;
    logic [4:0] act_lo;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e      = q.pop_front();
        act_hi = {hp2, hp1, hp0, hvalid, hmulti};
        act_lo = {lp2, lp1, lp0, lvalid, lmulti};
        total++;
        if (act_hi !== e.hi) begin
          bad++;
          $display("FAIL hi_prio {P,valid,multi}: got %b want %b", act_hi, e.hi);
        end
        total++;
        if (act_lo !== e.lo) begin
          bad++;
          $display("FAIL lo_prio {P,valid,multi}: got %b want %b", act_lo, e.lo);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held for two edges with a request pending.
    drive(1'b1, 8'b11110111, 5'b000_0_0, 5'b000_0_0);
    drive(1'b1, 8'b11110111, 5'b000_0_0, 5'b000_0_0);
    drive(1'b0, 8'b11110111, 5'b011_1_0, 5'b011_1_0);

    // Walking zero: single requests.
    drive(1'b0, 8'b11111110, 5'b000_1_0, 5'b000_1_0);
    drive(1'b0, 8'b11111101, 5'b001_1_0, 5'b001_1_0);
    drive(1'b0, 8'b11111011, 5'b010_1_0, 5'b010_1_0);
    drive(1'b0, 8'b11110111, 5'b011_1_0, 5'b011_1_0);
    drive(1'b0, 8'b11101111, 5'b100_1_0, 5'b100_1_0);
    drive(1'b0, 8'b11011111, 5'b101_1_0, 5'b101_1_0);
    drive(1'b0, 8'b10111111, 5'b110_1_0, 5'b110_1_0);
    drive(1'b0, 8'b01111111, 5'b111_1_0, 5'b111_1_0);

    // No request.
    drive(1'b0, 8'b11111111, 5'b000_0_0, 5'b000_0_0);

    // Priority between multiple requests.
    drive(1'b0, 8'b00000000, 5'b111_1_1, 5'b000_1_1);
    drive(1'b0, 8'b11100101, 5'b100_1_1, 5'b001_1_1);
    drive(1'b0, 8'b01111110, 5'b111_1_1, 5'b000_1_1);

    // Back-to-back changes, then a glitch between edges that must be missed.
    drive(1'b0, 8'b11111101, 5'b001_1_0, 5'b001_1_0);
    drive(1'b0, 8'b10111111, 5'b110_1_0, 5'b110_1_0);
    drive(1'b0, 8'b11111101, 5'b001_1_0, 5'b001_1_0);
    #1 x = 8'b00000000;
    #1 x = 8'b11111101;

    // Reset mid-stream.
    drive(1'b0, 8'b01111111, 5'b111_1_0, 5'b111_1_0);
    drive(1'b1, 8'b01111111, 5'b000_0_0, 5'b000_0_0);
    drive(1'b0, 8'b01111111, 5'b111_1_0, 5'b111_1_0);

    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_encoder8to3_reg
